// File: rtl/tap_reduce_tree_pkg.sv
// rtl/tap_reduce_tree_pkg.sv - shared sizing helpers for the tap reduction tree
package tap_reduce_tree_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_TAPS = 6;

    // Number of registered adder levels needed to fold n elements into one
    function automatic int tree_levels(int n);
        return $clog2(n);
    endfunction

    // Sum width that cannot overflow when adding n signed w-bit values
    function automatic int sum_width(int w, int n);
        return w + $clog2(n);
    endfunction

    // Width able to hold a count from 0 to n inclusive
    function automatic int cnt_width(int n);
        return $clog2(n + 1);
    endfunction

    // Element count entering adder level lv (level 0 sees all n taps)
    function automatic int level_elems(int n, int lv);
        int e;
        e = n;
        for (int i = 0; i < lv; i++) begin
            e = (e + 1) / 2;
        end
        return e;
    endfunction

    // Element offset of level lv inside the flattened tree vector
    function automatic int level_offset(int n, int lv);
        int o;
        o = 0;
        for (int j = 0; j < lv; j++) begin
            o = o + level_elems(n, j);
        end
        return o;
    endfunction

    localparam int DEF_SUM_W = sum_width(DEF_WIDTH, DEF_NUM_TAPS);
    localparam int DEF_CNT_W = cnt_width(DEF_NUM_TAPS);

endpackage

// File: rtl/tap_reduce_tree_add_level.sv
// rtl/tap_reduce_tree_add_level.sv - one registered pairwise adder level with odd pass-through
module add_level #(
    parameter int N_IN = 6,
    parameter int EW   = 35
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN*EW-1:0]           i_data,
    output logic [((N_IN+1)/2)*EW-1:0]   o_data
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*EW-1:0] w_next;
    logic [N_OUT*EW-1:0] r_data;

    // Add adjacent pairs; an unpaired last element is forwarded unchanged
    always_comb begin
        w_next = '0;
        for (int k = 0; k < N_IN / 2; k++) begin
            w_next[k*EW +: EW] = i_data[(2*k)*EW +: EW] + i_data[(2*k+1)*EW +: EW];
        end
        if (N_IN % 2 == 1) begin
            w_next[(N_OUT-1)*EW +: EW] = i_data[(N_IN-1)*EW +: EW];
        end
    end

    // Level register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/tap_reduce_tree.sv
// rtl/tap_reduce_tree.sv - masked signed sum of a tap window through a registered adder tree
module tap_reduce_tree
    import tap_reduce_tree_pkg::*;
#(
    parameter int width   = 32,
    parameter int numTaps = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [numTaps*width-1:0]                 taps,
    input  logic                                     tap0_vld,
    input  logic                                     clr,
    output logic [sum_width(width, numTaps)-1:0]     sum,
    output logic                                     sum_vld,
    output logic [cnt_width(numTaps)-1:0]            sum_cnt,
    output logic                                     sum_full
);

    localparam int LEVELS = tree_levels(numTaps);
    localparam int SW     = sum_width(width, numTaps);
    localparam int CW     = cnt_width(numTaps);
    localparam int EXT    = SW - width;
    localparam int TOTAL  = level_offset(numTaps, LEVELS + 1);

    // Only the older numTaps-1 bits are stored; tap 0 always uses tap0_vld live
    logic [numTaps-2:0]      r_vmask;
    logic [numTaps-1:0]      w_mask;
    logic [numTaps*SW-1:0]   w_ext;
    logic [CW-1:0]           w_cnt;

    logic [numTaps*SW-1:0]   r_s0_data;
    logic [CW-1:0]           r_s0_cnt;
    logic                    r_s0_full;
    logic                    r_s0_vld;

    logic [CW-1:0]           r_cnt_d [LEVELS];
    logic [LEVELS-1:0]       r_full_d;
    logic [LEVELS-1:0]       r_vld_d;

    logic [TOTAL*SW-1:0]     w_tree;

    // Mask seen by the taps this cycle; a flush invalidates the whole window
    always_comb begin
        w_mask = clr ? '0 : {r_vmask, tap0_vld};
    end

    // Valid history shifts in step with the upstream tap pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vmask <= '0;
        end else begin
            r_vmask <= w_mask[numTaps-2:0];
        end
    end

    // Sign-extend each tap to full sum width, zero masked taps, count valid ones
    always_comb begin
        w_ext = '0;
        w_cnt = '0;
        for (int i = 0; i < numTaps; i++) begin
            if (w_mask[i]) begin
                w_ext[i*SW +: SW] = {{EXT{taps[width*(i+1)-1]}}, taps[i*width +: width]};
            end
            w_cnt = w_cnt + CW'(w_mask[i]);
        end
    end

    // Stage 0 register: masked operands plus the flags that ride with them
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0_data <= '0;
            r_s0_cnt  <= '0;
            r_s0_full <= 1'b0;
            r_s0_vld  <= 1'b0;
        end else begin
            r_s0_data <= w_ext;
            r_s0_cnt  <= w_cnt;
            r_s0_full <= &w_mask;
            r_s0_vld  <= tap0_vld & ~clr;
        end
    end

    // Flag delay line matching the adder tree depth
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LEVELS; k++) begin
                r_cnt_d[k] <= '0;
            end
            r_full_d <= '0;
            r_vld_d  <= '0;
        end else begin
            r_cnt_d[0]  <= r_s0_cnt;
            r_full_d[0] <= r_s0_full;
            r_vld_d[0]  <= r_s0_vld;
            for (int k = 1; k < LEVELS; k++) begin
                r_cnt_d[k]  <= r_cnt_d[k-1];
                r_full_d[k] <= r_full_d[k-1];
                r_vld_d[k]  <= r_vld_d[k-1];
            end
        end
    end

    // All tree levels live back to back in one flat vector, level 0 first
    assign w_tree[0 +: numTaps*SW] = r_s0_data;

    genvar lv;
    generate
        for (lv = 0; lv < LEVELS; lv++) begin : g_lvl
            localparam int NI    = level_elems(numTaps, lv);
            localparam int NO    = (NI + 1) / 2;
            localparam int OFF_I = level_offset(numTaps, lv);
            localparam int OFF_O = level_offset(numTaps, lv + 1);

            add_level #(
                .N_IN (NI),
                .EW   (SW)
            ) u_add (
                .clk    (clk),
                .rst    (rst),
                .i_data (w_tree[OFF_I*SW +: NI*SW]),
                .o_data (w_tree[OFF_O*SW +: NO*SW])
            );
        end
    endgenerate

    assign sum      = w_tree[(TOTAL-1)*SW +: SW];
    assign sum_cnt  = r_cnt_d[LEVELS-1];
    assign sum_full = r_full_d[LEVELS-1];
    assign sum_vld  = r_vld_d[LEVELS-1];

endmodule
